// File: rtl/fifo_pkg.sv
// Shared FIFO types and width helpers.
package fifo_pkg;

   typedef enum logic {
      FIFO_REG  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/sfifo_ram.sv
// FIFO storage: one clocked write port, one asynchronous read port.
module sfifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, fill count, flags, sticky errors,
// registered or first-word-fall-through read.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_rq,
   input  logic [WIDTH-1:0]   wdata,
   input  logic               rd_rq,
   output logic [WIDTH-1:0]   rdata,
   output logic               rvalid,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic               almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic               overflow,
   output logic               underflow,
   input  logic               clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;

   typedef logic [PW-1:0] fifo_ptr_t;
   typedef logic [CW-1:0] fifo_cnt_t;

   localparam fifo_ptr_t PTR_ONE = fifo_ptr_t'(1);
   localparam fifo_cnt_t CNT_ONE = fifo_cnt_t'(1);
   localparam fifo_cnt_t AF_C    = fifo_cnt_t'(AF_THRESH);
   localparam fifo_cnt_t AE_C    = fifo_cnt_t'(AE_THRESH);

   if (!is_pow2(DEPTH)) begin : g_chk_depth
      $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2");
   end
   if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_chk_thr
      $error("sync_fifo_ctrl: need AE_THRESH < AF_THRESH <= DEPTH");
   end
   if (WIDTH < 1) begin : g_chk_width
      $error("sync_fifo_ctrl: WIDTH must be >= 1");
   end

   fifo_ptr_t        r_wptr;
   fifo_ptr_t        r_rptr;
   fifo_cnt_t        r_count;
   logic             r_ovf;
   logic             r_udf;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [WIDTH-1:0] w_ram_rdata;

   // Same address with opposite wrap bits means the writer lapped the reader.
   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                     (r_wptr[AW] != r_rptr[AW]);
   assign w_wr_acc = wr_rq & ~w_full;
   assign w_rd_acc = rd_rq & ~w_empty;

   sfifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (w_wr_acc),
      .waddr (r_wptr[AW-1:0]),
      .wdata (wdata),
      .raddr (r_rptr[AW-1:0]),
      .rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
         if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // A new error event takes priority over a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (wr_rq & w_full) | (r_ovf & ~clr_err);
         r_udf <= (rd_rq & w_empty) | (r_udf & ~clr_err);
      end
   end

   if (MODE == FIFO_FWFT) begin : g_fwft
      assign rdata  = w_ram_rdata;
      assign rvalid = ~w_empty;
   end else begin : g_reg
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
         end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) r_rdata <= w_ram_rdata;
         end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= AF_C);
   assign almost_empty = (r_count <= AE_C);
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: registered-read and FWFT instances
// share stimulus; each scenario task checks its own expectations.
module tb_sync_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_rq = 1'b0;
   logic [7:0] wdata = '0;
   logic       rd_rq = 1'b0;
   logic       clr_err = 1'b0;

   logic [7:0] rdata;
   logic       rvalid, full, empty, afull, aempty, ovf, udf;
   logic [4:0] count;

   logic [7:0] f_rdata;
   logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [4:0] f_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(
      .WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)
   ) u_reg (
      .clk(clk), .rst(rst), .wr_rq(wr_rq), .wdata(wdata), .rd_rq(rd_rq),
      .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
      .almost_full(afull), .almost_empty(aempty), .count(count),
      .overflow(ovf), .underflow(udf), .clr_err(clr_err)
   );

   sync_fifo_ctrl #(
      .WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)
   ) u_fwft (
      .clk(clk), .rst(rst), .wr_rq(wr_rq), .wdata(wdata), .rd_rq(rd_rq),
      .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_errs();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
   endtask

   task automatic test_reset();
      step();
      n_cmp++;
      if ({count, empty, full, aempty, afull} !== {5'd0, 4'b1010}) begin
         n_bad++;
         $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b required 0 1 0 1 0",
                  count, empty, full, aempty, afull);
      end
      n_cmp++;
      if ({rvalid, rdata, ovf, udf} !== 11'd0) begin
         n_bad++;
         $display("FAIL reset_out: got rv=%b rd=%h ov=%b un=%b required all 0",
                  rvalid, rdata, ovf, udf);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         wr_rq = 1'b1;
         wdata = 8'(i);
         step();
         n_cmp++;
         if (count !== 5'(i + 1)) begin
            n_bad++;
            $display("FAIL fill_count[%0d]: got %0d required %0d", i, count, i + 1);
         end
         n_cmp++;
         if ({full, afull, aempty, ovf} !== {i == 15, i + 1 >= 14, i + 1 <= 2, 1'b0}) begin
            n_bad++;
            $display("FAIL fill_flags[%0d]: got f=%b af=%b ae=%b ov=%b", i, full, afull, aempty, ovf);
         end
      end
      wdata = 8'h10;
      step();
      wr_rq = 1'b0;
      n_cmp++;
      if ({ovf, full, count} !== {2'b11, 5'd16}) begin
         n_bad++;
         $display("FAIL fill_overflow: got ov=%b f=%b cnt=%0d required 1 1 16", ovf, full, count);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 16; i++) begin
         rd_rq = 1'b1;
         step();
         n_cmp++;
         if ({rvalid, rdata, count} !== {1'b1, 8'(i), 5'(15 - i)}) begin
            n_bad++;
            $display("FAIL drain[%0d]: got rv=%b rd=%h cnt=%0d required 1 %h %0d",
                     i, rvalid, rdata, count, 8'(i), 15 - i);
         end
      end
      n_cmp++;
      if (empty !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_empty: got %b required 1", empty);
      end
      step();
      rd_rq = 1'b0;
      n_cmp++;
      if ({udf, rvalid, rdata, count} !== {2'b10, 8'h0F, 5'd0}) begin
         n_bad++;
         $display("FAIL drain_underflow: got un=%b rv=%b rd=%h cnt=%0d required 1 0 0f 0",
                  udf, rvalid, rdata, count);
      end
      clear_errs();
      n_cmp++;
      if ({ovf, udf} !== 2'b00) begin
         n_bad++;
         $display("FAIL clr_err: got ov=%b un=%b required 0 0", ovf, udf);
      end
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 10; k++) begin
            wr_rq = 1'b1;
            wdata = 8'(8'h20 + r * 16 + k);
            step();
            n_cmp++;
            if (count !== 5'(k + 1)) begin
               n_bad++;
               $display("FAIL wrap_wcnt[%0d.%0d]: got %0d required %0d", r, k, count, k + 1);
            end
         end
         wr_rq = 1'b0;
         for (int k = 0; k < 10; k++) begin
            rd_rq = 1'b1;
            step();
            n_cmp++;
            if ({rdata, count} !== {8'(8'h20 + r * 16 + k), 5'(9 - k)}) begin
               n_bad++;
               $display("FAIL wrap_rd[%0d.%0d]: got rd=%h cnt=%0d required %h %0d",
                        r, k, rdata, count, 8'(8'h20 + r * 16 + k), 9 - k);
            end
         end
         rd_rq = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         wr_rq = 1'b1;
         wdata = 8'(8'h40 + i);
         step();
      end
      rd_rq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wdata = 8'(8'h45 + i);
         step();
         n_cmp++;
         if ({rvalid, rdata, count} !== {1'b1, 8'(8'h40 + i), 5'd5}) begin
            n_bad++;
            $display("FAIL b2b[%0d]: got rv=%b rd=%h cnt=%0d required 1 %h 5",
                     i, rvalid, rdata, count, 8'(8'h40 + i));
         end
      end
      wr_rq = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (rdata !== 8'(8'h54 + i)) begin
            n_bad++;
            $display("FAIL b2b_tail[%0d]: got %h required %h", i, rdata, 8'(8'h54 + i));
         end
      end
      rd_rq = 1'b0;
      clear_errs();
      for (int i = 0; i < 16; i++) begin
         wr_rq = 1'b1;
         wdata = 8'(8'h60 + i);
         step();
      end
      rd_rq = 1'b1;
      wdata = 8'hEE;
      step();
      wr_rq = 1'b0;
      n_cmp++;
      if ({rdata, count, ovf, full} !== {8'h60, 5'd15, 2'b10}) begin
         n_bad++;
         $display("FAIL full_both: got rd=%h cnt=%0d ov=%b f=%b required 60 15 1 0",
                  rdata, count, ovf, full);
      end
      for (int i = 1; i < 16; i++) begin
         step();
         n_cmp++;
         if (rdata !== 8'(8'h60 + i)) begin
            n_bad++;
            $display("FAIL full_drain[%0d]: got %h required %h", i, rdata, 8'(8'h60 + i));
         end
      end
      wr_rq = 1'b1;
      wdata = 8'h77;
      step();
      wr_rq = 1'b0;
      n_cmp++;
      if ({count, rvalid, udf, rdata} !== {5'd1, 2'b01, 8'h6F}) begin
         n_bad++;
         $display("FAIL empty_both: got cnt=%0d rv=%b un=%b rd=%h required 1 0 1 6f",
                  count, rvalid, udf, rdata);
      end
      step();
      rd_rq = 1'b0;
      n_cmp++;
      if ({rdata, count, empty} !== {8'h77, 5'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL empty_both_rd: got rd=%h cnt=%0d e=%b required 77 0 1", rdata, count, empty);
      end
      clear_errs();
   endtask

   task automatic test_fwft();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({f_empty, f_rvalid} !== 2'b10) begin
         n_bad++;
         $display("FAIL fwft_reset: got e=%b rv=%b required 1 0", f_empty, f_rvalid);
      end
      wr_rq = 1'b1;
      wdata = 8'hA5;
      step();
      wr_rq = 1'b0;
      n_cmp++;
      if ({f_rvalid, f_rdata, f_count} !== {1'b1, 8'hA5, 5'd1}) begin
         n_bad++;
         $display("FAIL fwft_present: got rv=%b rd=%h cnt=%0d required 1 a5 1",
                  f_rvalid, f_rdata, f_count);
      end
      step();
      n_cmp++;
      if ({f_rvalid, f_rdata} !== {1'b1, 8'hA5}) begin
         n_bad++;
         $display("FAIL fwft_hold: got rv=%b rd=%h required 1 a5", f_rvalid, f_rdata);
      end
      rd_rq = 1'b1;
      step();
      rd_rq = 1'b0;
      n_cmp++;
      if ({f_empty, f_rvalid, f_count} !== {2'b10, 5'd0}) begin
         n_bad++;
         $display("FAIL fwft_pop: got e=%b rv=%b cnt=%0d required 1 0 0", f_empty, f_rvalid, f_count);
      end
      wr_rq = 1'b1;
      wdata = 8'h11;
      step();
      wdata = 8'h22;
      step();
      wr_rq = 1'b0;
      n_cmp++;
      if (f_rdata !== 8'h11) begin
         n_bad++;
         $display("FAIL fwft_head1: got %h required 11", f_rdata);
      end
      rd_rq = 1'b1;
      step();
      rd_rq = 1'b0;
      n_cmp++;
      if ({f_rvalid, f_rdata} !== {1'b1, 8'h22}) begin
         n_bad++;
         $display("FAIL fwft_head2: got rv=%b rd=%h required 1 22", f_rvalid, f_rdata);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 8; i++) begin
         wr_rq = 1'b1;
         wdata = 8'(8'h30 + i);
         step();
      end
      wr_rq = 1'b0;
      rd_rq = 1'b1;
      step();
      rd_rq = 1'b0;
      wr_rq = 1'b1;
      wdata = 8'hC3;
      n_cmp++;
      if ({count, rvalid, rdata} !== {5'd7, 1'b1, 8'h30}) begin
         n_bad++;
         $display("FAIL mid_pre: got cnt=%0d rv=%b rd=%h required 7 1 30", count, rvalid, rdata);
      end
      rst = 1'b1;
      #2;
      n_cmp++;
      if ({count, empty, full, aempty, afull, rvalid, rdata} !== {5'd0, 4'b1010, 9'd0}) begin
         n_bad++;
         $display("FAIL mid_async: got cnt=%0d e=%b f=%b ae=%b af=%b rv=%b rd=%h",
                  count, empty, full, aempty, afull, rvalid, rdata);
      end
      step();
      wr_rq = 1'b0;
      rst = 1'b0;
      rd_rq = 1'b1;
      step();
      rd_rq = 1'b0;
      n_cmp++;
      if ({udf, rvalid, count} !== {2'b10, 5'd0}) begin
         n_bad++;
         $display("FAIL mid_first_rd: got un=%b rv=%b cnt=%0d required 1 0 0", udf, rvalid, count);
      end
      for (int i = 0; i < 17; i++) begin
         wr_rq = 1'b1;
         wdata = 8'(i);
         step();
      end
      n_cmp++;
      if (ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_ovf: got %b required 1", ovf);
      end
      clr_err = 1'b1;
      step();
      wr_rq = 1'b0;
      n_cmp++;
      if ({ovf, udf} !== 2'b10) begin
         n_bad++;
         $display("FAIL set_wins: got ov=%b un=%b required 1 0", ovf, udf);
      end
      step();
      clr_err = 1'b0;
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_only: got %b required 0", ovf);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_fwft();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
